// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demultiplexer: channel count, select width
// and named channel indices.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t CH0 = 2'd0;
  localparam sel_t CH1 = 2'd1;
  localparam sel_t CH2 = 2'd2;
  localparam sel_t CH3 = 2'd3;

endpackage : demux_pkg

// File: rtl/demux_cct_if.sv
// Stream bundle between the source, the demultiplexer and the four channel consumers.
// Handshake: a word moves on m when m_valid & m_ready are both high at a rising clk edge;
// m_ready never depends on m_valid. A channel word is consumed when y_valid[i] & y_ack[i] are high at an edge.
interface demux_cct_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] m;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [NCH-1:0]   y_valid;
  logic [NCH-1:0]   y_ack;

  modport master (
    output m, m_valid, y_ack,
    input  m_ready, y0, y1, y2, y3, y_valid
  );

  modport slave (
    input  m, m_valid, y_ack,
    output m_ready, y0, y1, y2, y3, y_valid
  );

endinterface : demux_cct_if

// File: rtl/demux_chan_reg.sv
// One-entry channel holding register with valid flag. A load wins over an ack
// in the same cycle, so a consumed slot can be refilled without a bubble.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter bit HOLD  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ack && valid) begin
      valid <= 1'b0;
      if (!HOLD) q <= '0;
    end
  end

endmodule : demux_chan_reg

// File: rtl/demux_cct.sv
// 1-to-4 registered demultiplexer steered by {c1,c0} or by a round-robin counter,
// with per-channel holding registers that back-pressure the source.
module demux_cct
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter bit HOLD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  demux_cct_if.slave        bus,
  input  logic              c0,
  input  logic              c1,
  input  logic              auto_en,
  input  logic              sync,
  output logic              frame_done,
  output logic [SEL_W-1:0]  sel_cur
);

  sel_t             rr_cnt;
  sel_t             sel_eff;
  logic             accept;
  logic [NCH-1:0]   load;
  logic [NCH-1:0]   valid_q;
  logic [WIDTH-1:0] y_q [NCH];

  // sync forces channel 0 as the target even in explicit mode.
  always_comb begin
    if (sync)         sel_eff = CH0;
    else if (auto_en) sel_eff = rr_cnt;
    else              sel_eff = {c1, c0};
  end

  assign sel_cur     = sel_eff;
  assign bus.m_ready = ~rst & (~valid_q[sel_eff] | bus.y_ack[sel_eff]);
  assign accept      = bus.m_valid & bus.m_ready;

  always_comb begin
    load = '0;
    if (accept) load[sel_eff] = 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    demux_chan_reg #(
      .WIDTH (WIDTH),
      .HOLD  (HOLD)
    ) u_reg (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .d     (bus.m),
      .ack   (bus.y_ack[i]),
      .q     (y_q[i]),
      .valid (valid_q[i])
    );
  end

  assign bus.y0      = y_q[0];
  assign bus.y1      = y_q[1];
  assign bus.y2      = y_q[2];
  assign bus.y3      = y_q[3];
  assign bus.y_valid = valid_q;

  // A sync that coincides with an accept has already used channel 0, so the frame continues at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_cnt     <= CH0;
      frame_done <= 1'b0;
    end else begin
      if (sync)                    rr_cnt <= accept ? CH1 : CH0;
      else if (accept && auto_en)  rr_cnt <= rr_cnt + 2'd1;
      frame_done <= accept & auto_en & (sel_eff == CH3);
    end
  end

endmodule : demux_cct

// File: tb/tb_demux_cct.sv
// Bench for demux_cct (WIDTH=8): a HOLD=1 unit driven directly and a HOLD=0 unit
// sharing the same stimulus, with a queue of expected {channel, word} results.
module tb_demux_cct;
  import demux_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic c0, c1, auto_en, sync;
  logic frame_done, frame_done_h0;
  logic [1:0] sel_cur, sel_cur_h0;

  int checks   = 0;
  int failures = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] e;

  demux_cct_if #(.WIDTH(W)) bus ();
  demux_cct_if #(.WIDTH(W)) bus_h0 ();

  assign bus_h0.m       = bus.m;
  assign bus_h0.m_valid = bus.m_valid;
  assign bus_h0.y_ack   = bus.y_ack;

  demux_cct #(.WIDTH(W), .HOLD(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .c0(c0), .c1(c1), .auto_en(auto_en),
    .sync(sync), .frame_done(frame_done), .sel_cur(sel_cur)
  );

  demux_cct #(.WIDTH(W), .HOLD(1'b0)) dut_h0 (
    .clk(clk), .rst(rst), .bus(bus_h0), .c0(c0), .c1(c1), .auto_en(auto_en),
    .sync(sync), .frame_done(frame_done_h0), .sel_cur(sel_cur_h0)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] get_y(input logic [1:0] ch);
    case (ch)
      2'd0:    return bus.y0;
      2'd1:    return bus.y1;
      2'd2:    return bus.y2;
      default: return bus.y3;
    endcase
  endfunction

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [3:0] ack);
    bus.m_valid = v;
    bus.m       = d;
    bus.y_ack   = ack;
  endtask

  task automatic test_reset();
    rst = 1'b1; c0 = 0; c1 = 0; auto_en = 0; sync = 0;
    drive(1'b0, '0, 4'b0000);
    repeat (2) edge_sample();
    checks++;
    if ({bus.y0, bus.y1, bus.y2, bus.y3} !== 32'h0) begin
      failures++; $display("FAIL reset_y: actual=%h required=0", {bus.y0, bus.y1, bus.y2, bus.y3});
    end
    checks++;
    if (bus.y_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_y_valid: actual=%b required=0000", bus.y_valid);
    end
    checks++;
    if (bus.m_ready !== 1'b0) begin
      failures++; $display("FAIL reset_m_ready: actual=%b required=0", bus.m_ready);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done: actual=%b required=0", frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.m_ready !== 1'b1) begin
      failures++; $display("FAIL release_m_ready: actual=%b required=1", bus.m_ready);
    end
  endtask

  task automatic test_explicit();
    @(negedge clk);
    auto_en = 0; c1 = 1; c0 = 0;
    drive(1'b1, 8'hA5, 4'b0000);
    exp_q.push_back({CH2, 8'hA5});
    #1;
    checks++;
    if (sel_cur !== 2'd2) begin
      failures++; $display("FAIL expl_sel_cur: actual=%0d required=2", sel_cur);
    end
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0] || bus.y_valid !== 4'b0100) begin
      failures++; $display("FAIL expl_load: actual y=%h v=%b required y=%h v=0100", get_y(e[W+1:W]), bus.y_valid, e[W-1:0]);
    end
    @(negedge clk);
    drive(1'b1, 8'h5A, 4'b0000);
    #1;
    checks++;
    if (bus.m_ready !== 1'b0) begin
      failures++; $display("FAIL expl_full_ready: actual=%b required=0", bus.m_ready);
    end
    edge_sample();
    checks++;
    if (bus.y2 !== 8'hA5 || bus.y_valid !== 4'b0100) begin
      failures++; $display("FAIL expl_full_hold: actual y2=%h v=%b required y2=a5 v=0100", bus.y2, bus.y_valid);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 4'b0100);
    edge_sample();
    checks++;
    if (bus.y_valid !== 4'b0000 || bus.y2 !== 8'hA5) begin
      failures++; $display("FAIL expl_ack_hold1: actual y2=%h v=%b required y2=a5 v=0000", bus.y2, bus.y_valid);
    end
    checks++;
    if (bus_h0.y2 !== 8'h00 || bus_h0.y_valid !== 4'b0000) begin
      failures++; $display("FAIL expl_ack_hold0: actual y2=%h v=%b required y2=00 v=0000", bus_h0.y2, bus_h0.y_valid);
    end
  endtask

  task automatic test_auto_frame();
    logic [W-1:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    @(negedge clk);
    auto_en = 1; sync = 1;
    drive(1'b0, '0, 4'b0000);
    edge_sample();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sync = 0;
      drive(1'b1, words[i], 4'b1111);
      exp_q.push_back({i[1:0], words[i]});
      #1;
      checks++;
      if (bus.m_ready !== 1'b1 || sel_cur !== i[1:0]) begin
        failures++; $display("FAIL auto_ready_%0d: actual rdy=%b sel=%0d required rdy=1 sel=%0d", i, bus.m_ready, sel_cur, i);
      end
      edge_sample();
      e = exp_q.pop_front();
      checks++;
      if (get_y(e[W+1:W]) !== e[W-1:0] || bus.y_valid[e[W+1:W]] !== 1'b1) begin
        failures++; $display("FAIL auto_word_%0d: actual=%h required=%h", i, get_y(e[W+1:W]), e[W-1:0]);
      end
      checks++;
      if (frame_done !== (i == 3)) begin
        failures++; $display("FAIL auto_frame_done_%0d: actual=%b required=%b", i, frame_done, (i == 3));
      end
    end
    @(negedge clk);
    drive(1'b0, '0, 4'b0000);
    #1;
    checks++;
    if (sel_cur !== 2'd0 || bus.y_valid !== 4'b1000) begin
      failures++; $display("FAIL auto_wrap: actual sel=%0d v=%b required sel=0 v=1000", sel_cur, bus.y_valid);
    end
    edge_sample();
    checks++;
    if (frame_done !== 1'b0) begin
      failures++; $display("FAIL auto_frame_done_pulse: actual=%b required=0", frame_done);
    end
    @(negedge clk);
    drive(1'b0, '0, 4'b1000);
    edge_sample();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    auto_en = 0; c1 = 0; c0 = 1;
    drive(1'b1, 8'h22, 4'b0000);
    exp_q.push_back({CH1, 8'h22});
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0]) begin
      failures++; $display("FAIL b2b_preload: actual=%h required=%h", get_y(e[W+1:W]), e[W-1:0]);
    end
    @(negedge clk);
    drive(1'b1, 8'h55, 4'b0010);
    exp_q.push_back({CH1, 8'h55});
    #1;
    checks++;
    if (bus.m_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_ready: actual=%b required=1", bus.m_ready);
    end
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0] || bus.y_valid[1] !== 1'b1) begin
      failures++; $display("FAIL b2b_load: actual y=%h v=%b required y=%h v1=1", get_y(e[W+1:W]), bus.y_valid, e[W-1:0]);
    end
    @(negedge clk);
    drive(1'b0, '0, 4'b0010);
    edge_sample();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    auto_en = 1;
    drive(1'b1, 8'h60, 4'b0000);
    exp_q.push_back({CH0, 8'h60});
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0]) begin
      failures++; $display("FAIL bp_auto0: actual=%h required=%h", get_y(e[W+1:W]), e[W-1:0]);
    end
    @(negedge clk);
    auto_en = 0; c1 = 0; c0 = 1;
    drive(1'b1, 8'h61, 4'b0000);
    edge_sample();
    @(negedge clk);
    auto_en = 1;
    drive(1'b1, 8'h62, 4'b0000);
    #1;
    checks++;
    if (sel_cur !== 2'd1 || bus.m_ready !== 1'b0) begin
      failures++; $display("FAIL bp_stall: actual sel=%0d rdy=%b required sel=1 rdy=0", sel_cur, bus.m_ready);
    end
    edge_sample();
    checks++;
    if (sel_cur !== 2'd1 || bus.y1 !== 8'h61) begin
      failures++; $display("FAIL bp_hold: actual sel=%0d y1=%h required sel=1 y1=61", sel_cur, bus.y1);
    end
    @(negedge clk);
    bus.y_ack = 4'b0010;
    exp_q.push_back({CH1, 8'h62});
    #1;
    checks++;
    if (bus.m_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready: actual=%b required=1", bus.m_ready);
    end
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0] || bus.y_valid !== 4'b0011 || sel_cur !== 2'd2) begin
      failures++; $display("FAIL bp_release: actual y=%h v=%b sel=%0d required y=%h v=0011 sel=2", get_y(e[W+1:W]), bus.y_valid, sel_cur, e[W-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b0, '0, 4'b1111);
    edge_sample();
    @(negedge clk);
    sync = 1;
    drive(1'b1, 8'hAA, 4'b0000);
    exp_q.push_back({CH0, 8'hAA});
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0]) begin
      failures++; $display("FAIL mid_sync_word: actual=%h required=%h", get_y(e[W+1:W]), e[W-1:0]);
    end
    @(negedge clk);
    sync = 0;
    drive(1'b1, 8'hBB, 4'b0000);
    #1;
    checks++;
    if (sel_cur !== 2'd1) begin
      failures++; $display("FAIL mid_sync_advance: actual=%0d required=1", sel_cur);
    end
    edge_sample();
    @(negedge clk);
    rst = 1;
    drive(1'b0, '0, 4'b0000);
    #1;
    checks++;
    if (bus.m_ready !== 1'b0) begin
      failures++; $display("FAIL mid_rst_ready: actual=%b required=0", bus.m_ready);
    end
    edge_sample();
    checks++;
    if (bus.y_valid !== 4'b0000 || {bus.y0, bus.y1, bus.y2, bus.y3} !== 32'h0) begin
      failures++; $display("FAIL mid_rst_clear: actual v=%b y=%h required v=0000 y=0", bus.y_valid, {bus.y0, bus.y1, bus.y2, bus.y3});
    end
    @(negedge clk);
    rst = 0;
    drive(1'b1, 8'hCC, 4'b0000);
    exp_q.push_back({CH0, 8'hCC});
    #1;
    checks++;
    if (sel_cur !== 2'd0) begin
      failures++; $display("FAIL mid_first_sel: actual=%0d required=0", sel_cur);
    end
    edge_sample();
    e = exp_q.pop_front();
    checks++;
    if (get_y(e[W+1:W]) !== e[W-1:0] || bus.y_valid !== 4'b0001) begin
      failures++; $display("FAIL mid_first_word: actual y=%h v=%b required y=%h v=0001", get_y(e[W+1:W]), bus.y_valid, e[W-1:0]);
    end
    @(negedge clk);
    drive(1'b0, '0, 4'b0000);
  endtask

  task automatic test_random_explicit();
    logic [1:0]   ch;
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ch = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      auto_en = 0; {c1, c0} = ch;
      drive(1'b1, d, 4'b1111);
      exp_q.push_back({ch, d});
      edge_sample();
      e = exp_q.pop_front();
      checks++;
      if (get_y(e[W+1:W]) !== e[W-1:0] || bus.y_valid[e[W+1:W]] !== 1'b1) begin
        failures++; $display("FAIL rand_%0d: actual=%h required=%h ch=%0d", i, get_y(e[W+1:W]), e[W-1:0], e[W+1:W]);
      end
    end
    @(negedge clk);
    drive(1'b0, '0, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_auto_frame();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random_explicit();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_cct
